// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result stage: flag generation and 2-entry result FIFO
//
// Computes {N,Z,C,V} for each add/sub result and buffers sum and flags in order.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  push handshake for a/b/sub/sum
//   a, b, sub, sum     operands, operation select and result of the add/sub unit
//   flush              synchronous clear of all buffered entries
//   out_valid/ready    pop handshake for the head entry
//   out_data/out_flags head entry sum and {N,Z,C,V}, zero when empty
//   count              buffered entry count, 0..2
//   ovf_sticky         set when an entry with V=1 is popped
//   clr_sticky         synchronous clear of ovf_sticky
module alu_result_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  input  logic [7:0] sum,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_flags,
  output logic [1:0] count,
  output logic       ovf_sticky,
  input  logic       clr_sticky
);

  logic [1:0] r_count;
  logic       r_wptr;
  logic       r_rptr;
  logic [7:0] r_data  [0:1];
  logic [3:0] r_flags [0:1];
  logic       r_ovf;

  logic [7:0] w_b_eff;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic [3:0] w_flags;
  logic       w_push;
  logic       w_pop;
  logic       w_out_valid;

  // Flags are derived from the operands for C and V, and from the supplied
  // sum for N, Z and the sign comparison; the sum itself is never recomputed.
  assign w_b_eff = b ^ {8{sub}};
  assign w_n     = sum[7];
  assign w_z     = (sum == 8'h00);
  // Carry-out of the 9-bit sum, expressed as a range test on the full sum.
  assign w_c     = (({1'b0, a} + {1'b0, w_b_eff} + {8'd0, sub}) > 9'd255);
  assign w_v     = sub ? ((a[7] != b[7]) & (sum[7] != a[7]))
                       : ((a[7] == b[7]) & (sum[7] != a[7]));
  assign w_flags = {w_n, w_z, w_c, w_v};

  // in_ready is independent of out_ready: no pass-through while full.
  assign in_ready    = (r_count != 2'd2) & ~rst;
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = w_out_valid & out_ready;

  assign out_valid  = w_out_valid;
  assign out_data   = w_out_valid ? r_data[r_rptr]  : 8'h00;
  assign out_flags  = w_out_valid ? r_flags[r_rptr] : 4'h0;
  assign count      = r_count;
  assign ovf_sticky = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_data[0]  <= 8'h00;
      r_data[1]  <= 8'h00;
      r_flags[0] <= 4'h0;
      r_flags[1] <= 4'h0;
      r_ovf      <= 1'b0;
    end else begin
      if (flush) begin
        r_count <= 2'd0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
      end else begin
        if (w_push) begin
          r_data[r_wptr]  <= sum;
          r_flags[r_wptr] <= w_flags;
          r_wptr          <= ~r_wptr;
        end
        if (w_pop) begin
          r_rptr <= ~r_rptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end

      // A pop of an overflowed entry wins over a concurrent clear; a flush
      // drops the pop, so it cannot set the sticky bit.
      if (w_pop & ~flush & r_flags[r_rptr][0]) begin
        r_ovf <= 1'b1;
      end else if (clr_sticky) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic [7:0] sum;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_flags;
  logic [1:0] count;
  logic       ovf_sticky;
  logic       clr_sticky;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs [0:7];

  alu_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .sum        (sum),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flags  (out_flags),
    .count      (count),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] va, input logic [7:0] vb, input logic vs, input logic [7:0] vsum);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    sub      = vs;
    sum      = vsum;
  endtask

  initial begin
    // a, b, sub, sum, {N,Z,C,V}
    vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110};
    vecs[2] = '{8'h05, 8'h05, 1'b1, 8'h00, 4'b0110};
    vecs[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011};
    vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 4'b0000};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 4'b0111};
    // sum deliberately not a+b: it must be stored as given
    vecs[7] = '{8'h01, 8'h01, 1'b0, 8'h80, 4'b1001};

    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0; sum = 8'h00;
    flush = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    step();
    chk("rst_count", {6'd0, count}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_flags", {4'd0, out_flags}, 8'h00);
    chk("rst_ovf", {7'd0, ovf_sticky}, 8'd0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_in_ready", {7'd0, in_ready}, 8'd1);

    // Table: push one entry, check head, pop it, check sticky, clear sticky.
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), {7'd0, out_valid}, 8'd1);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].sum);
      chk($sformatf("v%0d_out_flags", i), {4'd0, out_flags}, {4'd0, vecs[i].flags});
      chk($sformatf("v%0d_count", i), {6'd0, count}, 8'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("v%0d_count_after_pop", i), {6'd0, count}, 8'd0);
      chk($sformatf("v%0d_data_empty", i), out_data, 8'h00);
      chk($sformatf("v%0d_ovf", i), {7'd0, ovf_sticky}, {7'd0, vecs[i].flags[0]});
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      chk($sformatf("v%0d_ovf_cleared", i), {7'd0, ovf_sticky}, 8'd0);
    end

    // Fill and drain
    push(8'h11, 8'h00, 1'b0, 8'h11);
    step();
    push(8'h22, 8'h00, 1'b0, 8'h22);
    step();
    chk("fill_count", {6'd0, count}, 8'd2);
    chk("fill_in_ready", {7'd0, in_ready}, 8'd0);
    chk("fill_head", out_data, 8'h11);
    push(8'h33, 8'h00, 1'b0, 8'h33);
    step();
    in_valid = 1'b0;
    chk("ignored_count", {6'd0, count}, 8'd2);
    chk("ignored_head", out_data, 8'h11);
    out_ready = 1'b1;
    step();
    chk("drain1_count", {6'd0, count}, 8'd1);
    chk("drain1_head", out_data, 8'h22);
    step();
    out_ready = 1'b0;
    chk("drain2_count", {6'd0, count}, 8'd0);
    chk("drain2_valid", {7'd0, out_valid}, 8'd0);
    chk("drain2_data", out_data, 8'h00);
    chk("drain2_flags", {4'd0, out_flags}, 8'h00);

    // Simultaneous push and pop with one entry
    push(8'h11, 8'h00, 1'b0, 8'h11);
    step();
    push(8'h44, 8'h00, 1'b0, 8'h44);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_count", {6'd0, count}, 8'd1);
    chk("pp_head", out_data, 8'h44);
    step();
    out_ready = 1'b0;
    chk("pp_drained", {6'd0, count}, 8'd0);

    // Set wins over clear on the same edge
    push(8'h7F, 8'h01, 1'b0, 8'h80);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    step();
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    chk("set_wins_ovf", {7'd0, ovf_sticky}, 8'd1);

    // Flush with full FIFO and a concurrent push/pop; sticky stays set
    push(8'h11, 8'h00, 1'b0, 8'h11);
    step();
    push(8'h22, 8'h00, 1'b0, 8'h22);
    step();
    chk("pre_flush_count", {6'd0, count}, 8'd2);
    push(8'h7F, 8'h01, 1'b0, 8'h80);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", {6'd0, count}, 8'd0);
    chk("flush_valid", {7'd0, out_valid}, 8'd0);
    chk("flush_in_ready", {7'd0, in_ready}, 8'd1);
    chk("flush_ovf", {7'd0, ovf_sticky}, 8'd1);
    push(8'h01, 8'h02, 1'b0, 8'h03);
    step();
    in_valid = 1'b0;
    chk("post_flush_head", out_data, 8'h03);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset mid-operation
    push(8'h11, 8'h00, 1'b0, 8'h11);
    step();
    push(8'h22, 8'h00, 1'b0, 8'h22);
    step();
    in_valid = 1'b0;
    chk("pre_rst_count", {6'd0, count}, 8'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", {6'd0, count}, 8'd0);
    chk("arst_valid", {7'd0, out_valid}, 8'd0);
    chk("arst_data", out_data, 8'h00);
    chk("arst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("arst_ovf", {7'd0, ovf_sticky}, 8'd0);
    #2 rst = 1'b0;
    push(8'h50, 8'h05, 1'b0, 8'h55);
    step();
    in_valid = 1'b0;
    chk("after_arst_count", {6'd0, count}, 8'd1);
    chk("after_arst_head", out_data, 8'h55);
    chk("after_arst_flags", {4'd0, out_flags}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
